snoop_receptor_mesi_n: RTL

SNOOP_RECEPTOR_MESI_N -- requirements
Module: snoop_receptor_mesi_n

---
 rtl/snoop_receptor_mesi_n.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/snoop_receptor_mesi_n.sv
// snoop_receptor_mesi_n
//
// Snoop receiver for a small MESI-coherent cache. It keeps a copy of
// NUM_LINHAS line entries (tag, MESI state, data), answers bus snoops
// (readMiss / writeMiss / invalidate) and performs the coherence transition
// on the line that matched. A modified line that is read or write-missed by
// another agent is first written back to memory. The response then tells
// the requester to abort its own memory access.
//
// Optional feature: define SNOOP_CONTADORES_EN to build the saturating hit
// and writeback statistics counters. Without it cont_hits/cont_wb are tied
// to zero and no counter registers exist.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   bus_valid/bus_ready            snoop request handshake
//   bus_op[1:0], bus_tag           01 readMiss, 10 writeMiss, 11 invalidate, 00 no-op
//   set_valid/set_ready            local cache line-entry write handshake
//   set_idx, set_tag,
//   set_estado, set_dado           entry index and contents
//   wb_valid/wb_ready              writeback handshake to memory
//   wb_tag, wb_dado                writeback payload
//   resp_valid                     one-cycle response pulse
//   resp_hit, resp_shared,
//   aborta_acesso_memoria          response flags
//   cont_hits, cont_wb             statistics counters

module snoop_receptor_mesi_n #(
  parameter int NUM_LINHAS = 4,
  parameter int TAG_W      = 8,
  parameter int DATA_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bus_valid,
  output logic                          bus_ready,
  input  logic [1:0]                    bus_op,
  input  logic [TAG_W-1:0]              bus_tag,
  input  logic                          set_valid,
  output logic                          set_ready,
  input  logic [$clog2(NUM_LINHAS)-1:0] set_idx,
  input  logic [TAG_W-1:0]              set_tag,
  input  logic [1:0]                    set_estado,
  input  logic [DATA_W-1:0]             set_dado,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [TAG_W-1:0]              wb_tag,
  output logic [DATA_W-1:0]             wb_dado,
  output logic                          resp_valid,
  output logic                          resp_hit,
  output logic                          resp_shared,
  output logic                          aborta_acesso_memoria,
  output logic [15:0]                   cont_hits,
  output logic [15:0]                   cont_wb
);

  localparam int IDX_W = $clog2(NUM_LINHAS);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RM  = 2'b01;
  localparam logic [1:0] OP_INV = 2'b11;

  typedef enum logic [1:0] {
    M_I = 2'b00,
    M_S = 2'b01,
    M_E = 2'b10,
    M_M = 2'b11
  } mesi_e;

  typedef enum logic [1:0] {
    OCIOSO,
    BUSCA,
    ESCRITA_WB,
    RESPOSTA
  } fsm_e;

  fsm_e estado_q, estado_d;

  mesi_e             line_est  [NUM_LINHAS];
  logic [TAG_W-1:0]  line_tag  [NUM_LINHAS];
  logic [DATA_W-1:0] line_dado [NUM_LINHAS];

  logic [1:0]        op_q;
  logic [TAG_W-1:0]  tag_q;
  logic              hit_q, shared_q, wb_q;
  logic [TAG_W-1:0]  wb_tag_q;
  logic [DATA_W-1:0] wb_dado_q;

  logic              bus_fire, set_fire;
  logic              match, need_wb;
  logic [IDX_W-1:0]  match_idx;
  mesi_e             match_est;
  logic [TAG_W-1:0]  match_tag;
  logic [DATA_W-1:0] match_dado;

  // Ready signals are gated by rst_n so they read 0 while reset is held.
  // A pending snoop blocks entry writes: snoops win the shared port.
  assign bus_ready = rst_n & (estado_q == OCIOSO);
  assign set_ready = rst_n & (estado_q == OCIOSO) & ~bus_valid;
  assign bus_fire  = bus_valid & bus_ready;
  assign set_fire  = set_valid & set_ready;

  // Scan from the top index down so the lowest matching index is the one
  // left in the result when several valid lines carry the same tag.
  always_comb begin
    match      = 1'b0;
    match_idx  = '0;
    match_est  = M_I;
    match_tag  = '0;
    match_dado = '0;
    for (int i = NUM_LINHAS - 1; i >= 0; i--) begin
      if (line_est[i] != M_I && line_tag[i] == tag_q) begin
        match      = 1'b1;
        match_idx  = IDX_W'(i);
        match_est  = line_est[i];
        match_tag  = line_tag[i];
        match_dado = line_dado[i];
      end
    end
  end

  // Only a dirty line that another agent wants to read or own must be
  // flushed; an invalidate discards the dirty copy without a writeback.
  assign need_wb = match && (match_est == M_M) && (op_q != OP_INV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:     if (bus_fire && bus_op != OP_NOP) estado_d = BUSCA;
      BUSCA:      estado_d = need_wb ? ESCRITA_WB : RESPOSTA;
      ESCRITA_WB: if (wb_ready) estado_d = RESPOSTA;
      RESPOSTA:   estado_d = OCIOSO;
      default:    estado_d = OCIOSO;
    endcase
  end

  // Request capture on acceptance and response/writeback capture at the
  // end of the lookup, so the payload stays stable while memory stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_NOP;
      tag_q     <= '0;
      hit_q     <= 1'b0;
      shared_q  <= 1'b0;
      wb_q      <= 1'b0;
      wb_tag_q  <= '0;
      wb_dado_q <= '0;
    end else begin
      if (bus_fire) begin
        op_q  <= bus_op;
        tag_q <= bus_tag;
      end
      if (estado_q == BUSCA) begin
        hit_q     <= match;
        shared_q  <= match && (op_q == OP_RM);
        wb_q      <= need_wb;
        wb_tag_q  <= match_tag;
        wb_dado_q <= match_dado;
      end
    end
  end

  // Line storage. Any hit ends in S on readMiss and in I otherwise. Entry
  // writes can only happen in OCIOSO, so they never collide with the
  // coherence update made when leaving BUSCA. Indices past the last line
  // match no entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINHAS; i++) begin
        line_est[i]  <= M_I;
        line_tag[i]  <= '0;
        line_dado[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LINHAS; i++) begin
        if (estado_q == BUSCA && match && match_idx == IDX_W'(i)) begin
          line_est[i] <= (op_q == OP_RM) ? M_S : M_I;
        end else if (set_fire && set_idx == IDX_W'(i)) begin
          line_est[i]  <= mesi_e'(set_estado);
          line_tag[i]  <= set_tag;
          line_dado[i] <= set_dado;
        end
      end
    end
  end

  assign wb_valid              = (estado_q == ESCRITA_WB);
  assign wb_tag                = wb_tag_q;
  assign wb_dado               = wb_dado_q;
  assign resp_valid            = (estado_q == RESPOSTA);
  assign resp_hit              = resp_valid & hit_q;
  assign resp_shared           = resp_valid & shared_q;
  assign aborta_acesso_memoria = resp_valid & wb_q;

`ifdef SNOOP_CONTADORES_EN
  logic [15:0] cont_hits_q, cont_wb_q;

  // Hits are counted when the response goes out, writebacks when memory
  // accepts them; a request killed by reset contributes to neither.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_hits_q <= '0;
      cont_wb_q   <= '0;
    end else begin
      if (estado_q == RESPOSTA && hit_q && cont_hits_q != 16'hFFFF)
        cont_hits_q <= cont_hits_q + 16'd1;
      if (estado_q == ESCRITA_WB && wb_ready && cont_wb_q != 16'hFFFF)
        cont_wb_q <= cont_wb_q + 16'd1;
    end
  end

  assign cont_hits = cont_hits_q;
  assign cont_wb   = cont_wb_q;
`else
  assign cont_hits = '0;
  assign cont_wb   = '0;
`endif

endmodule
